// File: rtl/fp_convert_pipe_if.sv
// Converter pipeline bus: request/response handshakes, converter side-channel, flag controls.
// The slave modport is the pipeline itself; the master modport is its requester/converter environment.
package fp_convert_pkg;
  typedef enum logic [3:0] {
    W_S, WU_S, S_W, S_WU, W_D, WU_D, D_W, D_WU, S_D, D_S
  } FpConverterCommand;
  typedef logic [31:0] word_t;
  typedef logic [63:0] uint64_t;
  typedef logic [4:0]  fflags_t;
endpackage

interface fp_convert_pipe_if #(parameter int TAG_WIDTH = 4);
  import fp_convert_pkg::*;

  logic                 flush;
  logic                 reqValid;
  logic                 reqReady;
  FpConverterCommand    reqCommand;
  logic [2:0]           reqRoundingMode;
  word_t                reqIntSrc;
  uint64_t              reqFpSrc;
  logic [TAG_WIDTH-1:0] reqTag;

  FpConverterCommand    cvtCommand;
  logic [2:0]           cvtRoundingMode;
  word_t                cvtIntSrc;
  uint64_t              cvtFpSrc;
  word_t                cvtIntResult;
  uint64_t              cvtFpResult;
  logic                 cvtWriteFlags;
  fflags_t              cvtWriteFlagsValue;

  logic                 respValid;
  logic                 respReady;
  logic [TAG_WIDTH-1:0] respTag;
  logic                 respIntDest;
  word_t                respIntResult;
  uint64_t              respFpResult;
  fflags_t              respFlags;

  logic                 flagsClear;
  fflags_t              accFlags;

  modport slave (
    input  flush, reqValid, reqCommand, reqRoundingMode, reqIntSrc, reqFpSrc, reqTag,
    input  cvtIntResult, cvtFpResult, cvtWriteFlags, cvtWriteFlagsValue,
    input  respReady, flagsClear,
    output reqReady, cvtCommand, cvtRoundingMode, cvtIntSrc, cvtFpSrc,
    output respValid, respTag, respIntDest, respIntResult, respFpResult, respFlags, accFlags
  );

  modport master (
    output flush, reqValid, reqCommand, reqRoundingMode, reqIntSrc, reqFpSrc, reqTag,
    output cvtIntResult, cvtFpResult, cvtWriteFlags, cvtWriteFlagsValue,
    output respReady, flagsClear,
    input  reqReady, cvtCommand, cvtRoundingMode, cvtIntSrc, cvtFpSrc,
    input  respValid, respTag, respIntDest, respIntResult, respFpResult, respFlags, accFlags
  );
endinterface

// File: rtl/fp_convert_pipe.sv
// FP convert pipe: one operand stage feeding an external combinational converter, then a response FIFO.
// Latency 2 cycles request-accept to respValid with an empty FIFO; one request per cycle sustained.
// Backpressure: respReady low fills the FIFO, then stalls S1, then drops reqReady.
module fp_convert_pipe
  import fp_convert_pkg::*;
#(
  parameter int TAG_WIDTH  = 4,
  parameter int RESP_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  fp_convert_pipe_if.slave bus
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    FpConverterCommand    cmd;
    logic [2:0]           rm;
    word_t                int_src;
    uint64_t              fp_src;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 int_dest;
    word_t                int_res;
    uint64_t              fp_res;
    fflags_t              flags;
  } ent_t;

  logic             s1_vld_q, s1_vld_d;
  s1_t              s1_q, s1_d;
  ent_t             ent_q [RESP_DEPTH];
  ent_t             ent_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fflags_t          acc_q, acc_d;

  logic full, pop, push, accept, resp_vld;
  ent_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head     = ent_q[rd_ptr_q];
  assign resp_vld = (cnt_q != '0);
  assign full     = (cnt_q == CNT_W'(RESP_DEPTH));
  // Flush kills both FIFO ends and the request side for the whole cycle.
  assign pop      = resp_vld && bus.respReady && !bus.flush;
  assign push     = s1_vld_q && (!full || pop) && !bus.flush;
  assign bus.reqReady = !bus.flush && (!s1_vld_q || push);
  assign accept   = bus.reqValid && bus.reqReady;

  always_comb begin
    s1_d        = s1_q;
    s1_vld_d    = s1_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ent_d.tag      = s1_q.tag;
    ent_d.int_dest = s1_q.cmd inside {W_S, WU_S, W_D, WU_D};
    ent_d.int_res  = bus.cvtIntResult;
    ent_d.fp_res   = bus.cvtFpResult;
    ent_d.flags    = bus.cvtWriteFlags ? bus.cvtWriteFlagsValue : 5'd0;

    if (bus.flush) begin
      s1_vld_d = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (accept) begin
        s1_vld_d   = 1'b1;
        s1_d.cmd     = bus.reqCommand;
        s1_d.rm      = bus.reqRoundingMode;
        s1_d.int_src = bus.reqIntSrc;
        s1_d.fp_src  = bus.reqFpSrc;
        s1_d.tag     = bus.reqTag;
      end else if (push) begin
        s1_vld_d = 1'b0;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // A clear coinciding with a pop leaves only the popped flags.
    if (bus.flagsClear) acc_d = pop ? head.flags : 5'd0;
    else if (pop)       acc_d = acc_q | head.flags;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      if (push) ent_q[wr_ptr_q] <= ent_d;
    end
  end

  assign bus.cvtCommand      = s1_q.cmd;
  assign bus.cvtRoundingMode = s1_q.rm;
  assign bus.cvtIntSrc       = s1_q.int_src;
  assign bus.cvtFpSrc        = s1_q.fp_src;
  assign bus.respValid       = resp_vld;
  assign bus.respTag         = head.tag;
  assign bus.respIntDest     = head.int_dest;
  assign bus.respIntResult   = head.int_res;
  assign bus.respFpResult    = head.fp_res;
  assign bus.respFlags       = head.flags;
  assign bus.accFlags        = acc_q;

endmodule
